// File: rtl/cache_line_fill.sv
// Miss-side line fill engine: reads one cache line beat by beat from block RAM and presents it.
// Optional WRAP_FILL_EN macro selects critical-beat-first issue order.
module cache_line_fill #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned BLOCK_BYTES = 4,
   parameter int unsigned BEAT_BYTES  = 1,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     req_valid,
   output logic                                     req_ready,
   input  logic [ADDR_W-1:0]                        req_addr,
   output logic                                     mem_en,
   output logic [ADDR_W-$clog2(BEAT_BYTES)-1:0]     mem_addr,
   input  logic [8*BEAT_BYTES-1:0]                  mem_rdata,
   output logic                                     fill_valid,
   input  logic                                     fill_ready,
   output logic [8*BLOCK_BYTES-1:0]                 fill_data,
   output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]    fill_addr,
   output logic                                     busy
);

   localparam int unsigned BEATS  = BLOCK_BYTES / BEAT_BYTES;
   localparam int unsigned OFF_W  = $clog2(BLOCK_BYTES);
   localparam int unsigned BEAT_W = $clog2(BEAT_BYTES);
   localparam int unsigned BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned CNT_W  = $clog2(BEATS + 1);
   localparam int unsigned LINE_W = ADDR_W - OFF_W;
   localparam int unsigned MA_W   = ADDR_W - BEAT_W;
   localparam int unsigned LANE_W = 8 * BEAT_BYTES;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e                       state_q, state_d;
   logic [LINE_W-1:0]            line_addr_q;
   logic [BIDX_W-1:0]            beat_q;
   logic [CNT_W-1:0]             issue_cnt_q;
   logic [CNT_W-1:0]             cap_cnt_q;
   logic                         mem_en_q;
   logic [MA_W-1:0]              mem_addr_q;
   logic [8*BLOCK_BYTES-1:0]     line_q;
   logic [MEM_LATENCY-1:0]       pipe_v_q;
   logic [BIDX_W-1:0]            pipe_idx_q [MEM_LATENCY];

   logic                         accept;
   logic                         issue_done;
   logic                         cap_fire;
   logic                         cap_last;
   logic [BIDX_W-1:0]            start_beat;
   logic [BIDX_W-1:0]            beat_nxt;
   logic [LINE_W-1:0]            req_line;

   assign req_line = req_addr[ADDR_W-1:OFF_W];

`ifdef WRAP_FILL_EN
   assign start_beat = (BEATS > 1) ? BIDX_W'(req_addr >> BEAT_W) : '0;
`else
   logic unused_req_off;
   assign unused_req_off = ^req_addr[OFF_W-1:0];
   assign start_beat     = '0;
`endif

   assign beat_nxt   = (BEATS > 1) ? beat_q + 1'b1 : '0;
   assign accept     = req_valid && (state_q == StIdle);
   assign issue_done = (state_q == StIssue) && (issue_cnt_q == CNT_W'(BEATS));
   assign cap_fire   = pipe_v_q[MEM_LATENCY-1];
   assign cap_last   = cap_fire && (cap_cnt_q == CNT_W'(BEATS - 1));

   function automatic logic [MA_W-1:0] word_addr(input logic [LINE_W-1:0] line,
                                                 input logic [BIDX_W-1:0] beat);
      return (MA_W'(line) << (OFF_W - BEAT_W)) | MA_W'(beat);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (req_valid)  state_d = StIssue;
         StIssue: if (issue_done) state_d = StDrain;
         StDrain: if (cap_last)   state_d = StDone;
         StDone:  if (fill_ready) state_d = StIdle;
         default:                 state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_addr_q <= '0;
         beat_q      <= '0;
         issue_cnt_q <= '0;
         cap_cnt_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
         line_q      <= '0;
         pipe_v_q    <= '0;
         for (int i = 0; i < MEM_LATENCY; i++) pipe_idx_q[i] <= '0;
      end else begin
         // Each stage tracks one read the memory sampled; the last stage lines up with mem_rdata.
         pipe_v_q[0]   <= mem_en_q;
         pipe_idx_q[0] <= beat_q;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_v_q[i]   <= pipe_v_q[i-1];
            pipe_idx_q[i] <= pipe_idx_q[i-1];
         end

         if (accept) begin
            line_addr_q <= req_line;
            beat_q      <= start_beat;
            mem_addr_q  <= word_addr(req_line, start_beat);
            mem_en_q    <= 1'b1;
            issue_cnt_q <= CNT_W'(1);
            cap_cnt_q   <= '0;
            line_q      <= '0;
         end else if (state_q == StIssue) begin
            if (issue_done) begin
               mem_en_q <= 1'b0;
            end else begin
               beat_q      <= beat_nxt;
               mem_addr_q  <= word_addr(line_addr_q, beat_nxt);
               issue_cnt_q <= issue_cnt_q + 1'b1;
            end
         end

         if (cap_fire) begin
            line_q[pipe_idx_q[MEM_LATENCY-1]*LANE_W +: LANE_W] <= mem_rdata;
            cap_cnt_q <= cap_cnt_q + 1'b1;
         end
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign busy       = (state_q != StIdle);
   assign fill_valid = (state_q == StDone);
   assign mem_en     = mem_en_q;
   assign mem_addr   = mem_addr_q;
   assign fill_data  = line_q;
   assign fill_addr  = line_addr_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: default geometry plus a 16-byte/4-byte-beat/latency-2 build.
module tb_cache_line_fill;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Default instance
   logic        req_valid0 = 1'b0, req_ready0, mem_en0, fill_valid0, fill_ready0 = 1'b0, busy0;
   logic [15:0] req_addr0 = '0, mem_addr0;
   logic [7:0]  mem_rdata0;
   logic [31:0] fill_data0;
   logic [13:0] fill_addr0;

   cache_line_fill dut0 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid0),
      .req_ready  (req_ready0),
      .req_addr   (req_addr0),
      .mem_en     (mem_en0),
      .mem_addr   (mem_addr0),
      .mem_rdata  (mem_rdata0),
      .fill_valid (fill_valid0),
      .fill_ready (fill_ready0),
      .fill_data  (fill_data0),
      .fill_addr  (fill_addr0),
      .busy       (busy0)
   );

   always_ff @(posedge clk) if (mem_en0) mem_rdata0 <= mem_addr0[7:0];

   // Wide instance: 16-byte line, 4-byte beats, two-cycle memory
   logic         req_valid1 = 1'b0, req_ready1, mem_en1, fill_valid1, fill_ready1 = 1'b0, busy1;
   logic [15:0]  req_addr1 = '0;
   logic [13:0]  mem_addr1;
   logic [31:0]  mem_rdata1, mem_stage1;
   logic [127:0] fill_data1;
   logic [11:0]  fill_addr1;

   cache_line_fill #(
      .ADDR_W      (16),
      .BLOCK_BYTES (16),
      .BEAT_BYTES  (4),
      .MEM_LATENCY (2)
   ) dut1 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid1),
      .req_ready  (req_ready1),
      .req_addr   (req_addr1),
      .mem_en     (mem_en1),
      .mem_addr   (mem_addr1),
      .mem_rdata  (mem_rdata1),
      .fill_valid (fill_valid1),
      .fill_ready (fill_ready1),
      .fill_data  (fill_data1),
      .fill_addr  (fill_addr1),
      .busy       (busy1)
   );

   function automatic logic [31:0] mk_word(input logic [13:0] w);
      logic [7:0] b0;
      b0 = {w[5:0], 2'b00};
      return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
   endfunction

   always_ff @(posedge clk) begin
      if (mem_en1) mem_stage1 <= mk_word(mem_addr1);
      mem_rdata1 <= mem_stage1;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready0, 1);
      check({tag, "_mem"}, {mem_en0, mem_addr0}, 0);
      check({tag, "_fill"}, {fill_valid0, fill_addr0, fill_data0}, 0);
      check({tag, "_busy"}, busy0, 0);
   endtask

   logic [15:0]  exp_seq [4];
   logic [31:0]  held_data;
   logic [13:0]  held_addr;
   int           hits, lat, accepts, lowcnt, fills, beats;
   bit           acc_now, found;
   logic [31:0]  fdat [2];
   logic [13:0]  fadr [2];

   initial begin
`ifdef WRAP_FILL_EN
      exp_seq = '{16'h1236, 16'h1237, 16'h1234, 16'h1235};
`else
      exp_seq = '{16'h1234, 16'h1235, 16'h1236, 16'h1237};
`endif
      #2;
      check_reset_outputs("reset");
      #10 reset = 1'b0;

      // Basic fill of 0x1236: beat sequence, latency and data
      @(negedge clk);
      req_valid0 = 1'b1;
      req_addr0  = 16'h1236;
      tick();                                     // edge T
      req_valid0 = 1'b0;
      check("accept_busy", {busy0, req_ready0}, 2'b10);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         check($sformatf("mem_addr%0d", i), {mem_en0, mem_addr0}, {1'b1, exp_seq[i]});
      end
      tick();                                     // T+4
      check("t4_idle_mem", {mem_en0, fill_valid0}, 2'b00);
      tick();                                     // T+5
      check("t5_fill_valid", fill_valid0, 1);
      check("t5_fill_data", fill_data0, 32'h37363534);
      check("t5_fill_addr", fill_addr0, 14'h048D);

      // Hold fill_ready low with a second request pending
      held_data  = fill_data0;
      held_addr  = fill_addr0;
      req_valid0 = 1'b1;
      req_addr0  = 16'h0010;
      hits = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (fill_valid0 && !req_ready0 && busy0 && fill_data0 == held_data
             && fill_addr0 == held_addr) hits++;
      end
      check("hold_stable_cycles", hits, 3);
      fill_ready0 = 1'b1;
      tick();
      fill_ready0 = 1'b0;
      check("handshake_idle", {fill_valid0, req_ready0, busy0}, 3'b010);
      tick();                                     // second request accepted here
      check("second_accept", {busy0, mem_en0, mem_addr0}, {2'b11, 16'h0010});

      // Reset in the middle of the fill
      tick();
      reset = 1'b1;
      req_valid0 = 1'b0;
      #1;
      check_reset_outputs("midreset");
      tick();
      tick();
      reset = 1'b0;
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (fill_valid0 || busy0) hits++;
      end
      check("post_reset_quiet", hits, 0);

      // Fresh request after reset fills correctly
      req_valid0 = 1'b1;
      req_addr0  = 16'h0010;
      tick();
      req_valid0 = 1'b0;
      found = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
         tick();
         if (fill_valid0) begin
            found = 1'b1;
            lat = i;
         end
      end
      check("refill_latency", lat, 5);
      check("refill_data", fill_data0, 32'h13121110);
      check("refill_addr", fill_addr0, 14'h0004);
      fill_ready0 = 1'b1;
      tick();

      // Back-to-back requests, req_valid and fill_ready held high
      req_valid0 = 1'b1;
      req_addr0  = 16'h0020;
      accepts = 0; lowcnt = 0; fills = 0; beats = 0;
      for (int c = 0; c < 40 && fills < 2; c++) begin
         acc_now = req_valid0 && req_ready0;
         if (fill_valid0 && fill_ready0) begin
            fdat[fills] = fill_data0;
            fadr[fills] = fill_addr0;
            fills++;
         end
         tick();
         if (acc_now) begin
            accepts++;
            if (accepts == 1) req_addr0 = 16'h0104;
            else req_valid0 = 1'b0;
         end
         if (accepts == 1 && !busy0) lowcnt++;
         if (mem_en0) beats++;
      end
      req_valid0  = 1'b0;
      fill_ready0 = 1'b0;
      check("b2b_fills", fills, 2);
      check("b2b_accepts", accepts, 2);
      check("b2b_beats", beats, 8);
      check("b2b_idle_gap", lowcnt, 1);
      check("b2b_data0", {fadr[0], fdat[0]}, {14'h0008, 32'h23222120});
      check("b2b_data1", {fadr[1], fdat[1]}, {14'h0041, 32'h07060504});

      // Wide instance: 0x0040, four word reads, latency 2
      @(negedge clk);
      req_valid1 = 1'b1;
      req_addr1  = 16'h0040;
      tick();                                     // edge T
      req_valid1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         check($sformatf("w_mem_addr%0d", i), {mem_en1, mem_addr1}, {1'b1, 14'h0010 + 14'(i)});
      end
      tick();
      tick();                                     // T+5
      check("w_t5_not_valid", fill_valid1, 0);
      tick();                                     // T+6
      check("w_t6_fill_valid", fill_valid1, 1);
      check("w_fill_data", fill_data1, 128'h4F4E4D4C4B4A49484746454443424140);
      check("w_fill_addr", fill_addr1, 12'h004);
      fill_ready1 = 1'b1;
      tick();
      fill_ready1 = 1'b0;
      check("w_return_idle", {fill_valid1, busy1}, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
